// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps MIDI note-on/off events onto VOICES voices,
// retriggering matching notes, filling free voices first and stealing the oldest.
module voice_allocator #(
  parameter int VOICES    = 4,
  parameter int NOTE_BITS = 7
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          evValid,
  output logic                          evReady,
  input  logic                          evOn,
  input  logic [NOTE_BITS-1:0]          evNote,
  input  logic [NOTE_BITS-1:0]          evVelocity,
  input  logic                          allOff,
  output logic [VOICES-1:0]             voiceActive,
  output logic [VOICES*NOTE_BITS-1:0]   voiceNote,
  output logic [VOICES*NOTE_BITS-1:0]   voiceVelocity,
  output logic [VOICES-1:0]             voiceTrigger,
  output logic [7:0]                    stealCount,
  output logic                          overrun
);

  localparam int IW = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(VOICES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t                state_r;
  state_t                next_state_s;
  logic [IW-1:0]         scan_idx_r;
  logic                  ev_on_r;
  logic [NOTE_BITS-1:0]  ev_note_r;
  logic [NOTE_BITS-1:0]  ev_vel_r;
  logic                  match_found_r;
  logic [IW-1:0]         match_idx_r;
  logic                  free_found_r;
  logic [IW-1:0]         free_idx_r;
  logic [IW-1:0]         old_idx_r;
  logic [IW-1:0]         age_r [VOICES];
  logic [IW-1:0]         target_s;
  logic                  steal_s;

  assign evReady = (state_r == IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; allOff aborts any in-flight event
  always_comb begin
    next_state_s = state_r;
    if (allOff) begin
      next_state_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    next_state_s = evValid ? SCAN : IDLE;
        SCAN:    next_state_s = (scan_idx_r == LAST_IDX) ? COMMIT : SCAN;
        COMMIT:  next_state_s = IDLE;
        default: next_state_s = IDLE;
      endcase
    end
  end

  // Note-on target: retrigger match, else lowest free voice, else steal the oldest
  always_comb begin
    target_s = old_idx_r;
    steal_s  = 1'b0;
    if (match_found_r) begin
      target_s = match_idx_r;
    end else if (free_found_r) begin
      target_s = free_idx_r;
    end else begin
      target_s = old_idx_r;
      steal_s  = 1'b1;
    end
  end

  // Event capture, per-voice scan and table commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      voiceActive   <= {VOICES{1'b0}};
      voiceNote     <= {(VOICES*NOTE_BITS){1'b0}};
      voiceVelocity <= {(VOICES*NOTE_BITS){1'b0}};
      voiceTrigger  <= {VOICES{1'b0}};
      stealCount    <= 8'd0;
      overrun       <= 1'b0;
      ev_on_r       <= 1'b0;
      ev_note_r     <= {NOTE_BITS{1'b0}};
      ev_vel_r      <= {NOTE_BITS{1'b0}};
      scan_idx_r    <= {IW{1'b0}};
      match_found_r <= 1'b0;
      match_idx_r   <= {IW{1'b0}};
      free_found_r  <= 1'b0;
      free_idx_r    <= {IW{1'b0}};
      old_idx_r     <= {IW{1'b0}};
      for (int i = 0; i < VOICES; i++) age_r[i] <= IW'(i);
    end else begin
      voiceTrigger <= {VOICES{1'b0}};
      if (evValid && (state_r != IDLE)) overrun <= 1'b1;
      if (allOff) begin
        voiceActive   <= {VOICES{1'b0}};
        voiceNote     <= {(VOICES*NOTE_BITS){1'b0}};
        voiceVelocity <= {(VOICES*NOTE_BITS){1'b0}};
      end else begin
        case (state_r)
          IDLE: begin
            if (evValid) begin
              // velocity 0 note-on is a note-off
              ev_on_r       <= evOn && (evVelocity != {NOTE_BITS{1'b0}});
              ev_note_r     <= evNote;
              ev_vel_r      <= evVelocity;
              scan_idx_r    <= {IW{1'b0}};
              match_found_r <= 1'b0;
              free_found_r  <= 1'b0;
            end
          end
          SCAN: begin
            if (voiceActive[scan_idx_r] && !match_found_r &&
                (voiceNote[int'(scan_idx_r)*NOTE_BITS +: NOTE_BITS] == ev_note_r)) begin
              match_found_r <= 1'b1;
              match_idx_r   <= scan_idx_r;
            end
            if (!voiceActive[scan_idx_r] && !free_found_r) begin
              free_found_r <= 1'b1;
              free_idx_r   <= scan_idx_r;
            end
            if (age_r[scan_idx_r] == LAST_IDX) old_idx_r <= scan_idx_r;
            scan_idx_r <= scan_idx_r + IW'(1);
          end
          COMMIT: begin
            if (ev_on_r) begin
              voiceActive[target_s]                                  <= 1'b1;
              voiceTrigger[target_s]                                 <= 1'b1;
              voiceNote[int'(target_s)*NOTE_BITS +: NOTE_BITS]       <= ev_note_r;
              voiceVelocity[int'(target_s)*NOTE_BITS +: NOTE_BITS]   <= ev_vel_r;
              for (int i = 0; i < VOICES; i++) begin
                if (IW'(i) == target_s) age_r[i] <= {IW{1'b0}};
                else if (age_r[i] < age_r[target_s]) age_r[i] <= age_r[i] + IW'(1);
              end
              if (steal_s && (stealCount != 8'hFF)) stealCount <= stealCount + 8'd1;
            end else begin
              for (int i = 0; i < VOICES; i++) begin
                if (voiceActive[i] && (voiceNote[i*NOTE_BITS +: NOTE_BITS] == ev_note_r)) begin
                  voiceActive[i]                            <= 1'b0;
                  voiceNote[i*NOTE_BITS +: NOTE_BITS]       <= {NOTE_BITS{1'b0}};
                  voiceVelocity[i*NOTE_BITS +: NOTE_BITS]   <= {NOTE_BITS{1'b0}};
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: event-level reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_voice_allocator;
  localparam int V  = 4;
  localparam int NB = 7;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            evValid = 1'b0;
  logic            evReady;
  logic            evOn = 1'b0;
  logic [NB-1:0]   evNote = '0;
  logic [NB-1:0]   evVelocity = '0;
  logic            allOff = 1'b0;
  logic [V-1:0]    voiceActive;
  logic [V*NB-1:0] voiceNote;
  logic [V*NB-1:0] voiceVelocity;
  logic [V-1:0]    voiceTrigger;
  logic [7:0]      stealCount;
  logic            overrun;

  voice_allocator #(.VOICES(V), .NOTE_BITS(NB)) dut (
    .clk(clk), .rst_n(rst_n), .evValid(evValid), .evReady(evReady), .evOn(evOn),
    .evNote(evNote), .evVelocity(evVelocity), .allOff(allOff),
    .voiceActive(voiceActive), .voiceNote(voiceNote), .voiceVelocity(voiceVelocity),
    .voiceTrigger(voiceTrigger), .stealCount(stealCount), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit       m_act [V];
  int       m_note[V];
  int       m_vel [V];
  int       m_age [V];
  int       m_steal;
  bit       m_ovr;
  bit [V-1:0] m_trig;
  int       m_busy;
  bit       p_on;
  int       p_note, p_vel;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < V; i++) begin
      m_act[i] = 1'b0; m_note[i] = 0; m_vel[i] = 0; m_age[i] = i;
    end
    m_steal = 0; m_ovr = 1'b0; m_trig = '0; m_busy = 0;
  endtask

  task automatic model_apply();
    int k;
    if (p_on && p_vel != 0) begin
      k = -1;
      for (int i = 0; i < V; i++) if (k < 0 && m_act[i] && m_note[i] == p_note) k = i;
      for (int i = 0; i < V; i++) if (k < 0 && !m_act[i]) k = i;
      if (k < 0) begin
        for (int i = 0; i < V; i++) if (m_age[i] == V - 1) k = i;
        if (m_steal < 255) m_steal++;
      end
      for (int i = 0; i < V; i++) if (i != k && m_age[i] < m_age[k]) m_age[i]++;
      m_age[k] = 0;
      m_act[k] = 1'b1; m_note[k] = p_note; m_vel[k] = p_vel; m_trig[k] = 1'b1;
    end else begin
      for (int i = 0; i < V; i++)
        if (m_act[i] && m_note[i] == p_note) begin
          m_act[i] = 1'b0; m_note[i] = 0; m_vel[i] = 0;
        end
    end
  endtask

  // Model: an accepted event becomes visible V+1 edges later; busy meanwhile
  always @(posedge clk) begin
    if (rst_n) begin
      m_trig = '0;
      if (evValid && m_busy != 0) m_ovr = 1'b1;
      if (allOff) begin
        for (int i = 0; i < V; i++) begin m_act[i] = 1'b0; m_note[i] = 0; m_vel[i] = 0; end
        m_busy = 0;
      end else if (m_busy != 0) begin
        m_busy--;
        if (m_busy == 0) model_apply();
      end else if (evValid) begin
        p_on = evOn; p_note = int'(evNote); p_vel = int'(evVelocity);
        m_busy = V + 1;
      end
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    logic [V-1:0]    e_act;
    logic [V*NB-1:0] e_note, e_vel;
    for (int i = 0; i < V; i++) begin
      e_act[i] = m_act[i];
      e_note[i*NB +: NB] = NB'(m_note[i]);
      e_vel[i*NB +: NB]  = NB'(m_vel[i]);
    end
    chk("evReady", 32'(evReady), 32'(m_busy == 0));
    chk("voiceActive", 32'(voiceActive), 32'(e_act));
    chk("voiceNote", 32'(voiceNote), 32'(e_note));
    chk("voiceVelocity", 32'(voiceVelocity), 32'(e_vel));
    chk("voiceTrigger", 32'(voiceTrigger), 32'(m_trig));
    chk("stealCount", 32'(stealCount), 32'(m_steal));
    chk("overrun", 32'(overrun), 32'(m_ovr));
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input bit on, input int note, input int vel);
    evValid = 1'b1; evOn = on; evNote = NB'(note); evVelocity = NB'(vel);
    cyc(1);
    evValid = 1'b0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    model_reset();
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask

  initial begin
    model_reset();
    reset_dut();
    chk("rst_ready", 32'(evReady), 32'd1);
    chk("rst_active", 32'(voiceActive), 32'd0);
    chk("rst_steal", 32'(stealCount), 32'd0);

    // single note-on: visible V+1 edges after acceptance, one trigger pulse
    send(1'b1, 60, 100); cyc(4);
    chk("on_early_active", 32'(voiceActive), 32'd0);
    cyc(1);
    chk("on_active", 32'(voiceActive), 32'b0001);
    chk("on_note", 32'(voiceNote[6:0]), 32'd60);
    chk("on_vel", 32'(voiceVelocity[6:0]), 32'd100);
    chk("on_trig", 32'(voiceTrigger), 32'b0001);
    cyc(1);
    chk("on_trig_end", 32'(voiceTrigger), 32'd0);

    // steal: fifth note takes voice0
    reset_dut();
    send(1'b1, 60, 100); cyc(5);
    send(1'b1, 62, 100); cyc(5);
    send(1'b1, 64, 100); cyc(5);
    send(1'b1, 65, 100); cyc(5);
    chk("full_active", 32'(voiceActive), 32'b1111);
    send(1'b1, 67, 100); cyc(5);
    chk("steal_note0", 32'(voiceNote[6:0]), 32'd67);
    chk("steal_count", 32'(stealCount), 32'd1);
    chk("steal_trig", 32'(voiceTrigger), 32'b0001);
    send(1'b1, 69, 20); cyc(5);
    chk("steal2_note1", 32'(voiceNote[13:7]), 32'd69);
    chk("steal2_count", 32'(stealCount), 32'd2);

    // velocity-0 note-on is note-off; voice is then reused
    reset_dut();
    send(1'b1, 60, 100); cyc(5);
    send(1'b1, 60, 0); cyc(5);
    chk("off_active", 32'(voiceActive), 32'd0);
    chk("off_note", 32'(voiceNote[6:0]), 32'd0);
    chk("off_vel", 32'(voiceVelocity[6:0]), 32'd0);
    send(1'b0, 99, 0); cyc(5);
    send(1'b1, 62, 80); cyc(5);
    chk("reuse_active", 32'(voiceActive), 32'b0001);
    chk("reuse_note", 32'(voiceNote[6:0]), 32'd62);
    // allOff together with evValid in IDLE: event dropped, no overrun
    evValid = 1'b1; evOn = 1'b1; evNote = NB'(70); evVelocity = NB'(70); allOff = 1'b1;
    cyc(1);
    evValid = 1'b0; allOff = 1'b0;
    chk("ao_ev_ready", 32'(evReady), 32'd1);
    chk("ao_ev_ovr", 32'(overrun), 32'd0);
    cyc(5);
    chk("ao_ev_active", 32'(voiceActive), 32'd0);

    // retrigger same note
    reset_dut();
    send(1'b1, 60, 50); cyc(5);
    chk("retrig1_trig", 32'(voiceTrigger), 32'b0001);
    send(1'b1, 60, 90); cyc(5);
    chk("retrig2_trig", 32'(voiceTrigger), 32'b0001);
    chk("retrig_active", 32'(voiceActive), 32'b0001);
    chk("retrig_vel", 32'(voiceVelocity[6:0]), 32'd90);
    chk("retrig_steal", 32'(stealCount), 32'd0);

    // event during SCAN dropped; allOff during SCAN aborts
    reset_dut();
    send(1'b1, 60, 100);
    evValid = 1'b1; evOn = 1'b1; evNote = NB'(70); evVelocity = NB'(70);
    cyc(1);
    evValid = 1'b0;
    cyc(4);
    chk("ovr_flag", 32'(overrun), 32'd1);
    chk("ovr_active", 32'(voiceActive), 32'b0001);
    chk("ovr_note", 32'(voiceNote[6:0]), 32'd60);
    send(1'b1, 64, 100); cyc(1);
    allOff = 1'b1; cyc(1); allOff = 1'b0;
    chk("aoscan_active", 32'(voiceActive), 32'd0);
    chk("aoscan_ready", 32'(evReady), 32'd1);
    cyc(5);
    chk("aoscan_after", 32'(voiceActive), 32'd0);

    // async reset mid-SCAN
    reset_dut();
    send(1'b1, 61, 100); cyc(1);
    send(1'b1, 61, 100);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_ready", 32'(evReady), 32'd1);
    chk("arst_ovr", 32'(overrun), 32'd0);
    chk("arst_active", 32'(voiceActive), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(1);
    send(1'b1, 62, 33); cyc(5);
    chk("arst_next_active", 32'(voiceActive), 32'b0001);
    chk("arst_next_note", 32'(voiceNote[6:0]), 32'd62);
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 Parameter VOICES, default 4, number of synth voices shared between incoming MIDI notes; power of two, 2..16.
REQ-002 Parameter NOTE_BITS, default 7, width of MIDI note and velocity fields.
REQ-003 Port clk, input, 1, single system clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 Port evValid, input, 1, one-cycle strobe: MIDI key event present.
REQ-006 Port evReady, output, 1, allocator can accept an event this cycle.
REQ-007 Port evOn, input, 1, 1 = note-on, 0 = note-off.
REQ-008 Port evNote, input, NOTE_BITS, MIDI note number.
REQ-009 Port evVelocity, input, NOTE_BITS, MIDI velocity.
REQ-010 Port allOff, input, 1, one-cycle strobe: all-notes-off.
REQ-011 Port voiceActive, output, VOICES, per-voice gate.
REQ-012 Port voiceNote, output, VOICES*NOTE_BITS, per-voice note; voice i in bits [i*NOTE_BITS +: NOTE_BITS].
REQ-013 Port voiceVelocity, output, VOICES*NOTE_BITS, per-voice velocity; same packing.
REQ-014 Port voiceTrigger, output, VOICES, one-cycle pulse when a voice is (re)assigned.
REQ-015 Port stealCount, output, 8, count of voice steals; saturates at 255.
REQ-016 Port overrun, output, 1, sticky flag: an event arrived while evReady was 0.

Function
REQ-017 States: IDLE, SCAN, COMMIT; evReady = 1 only in IDLE.
REQ-018 IDLE: evValid=1 registers evOn/evNote/evVelocity, clears scan index, goes to SCAN.
REQ-019 SCAN examines voice index 0..VOICES-1, one voice per cycle, recording: first matching active voice, lowest-index free voice, and the voice with age VOICES-1; after the last index, goes to COMMIT.
REQ-020 COMMIT applies the update and returns to IDLE.
REQ-021 Latency: the acceptance edge is T; table outputs change at edge T+VOICES+1. Maximum throughput is one event per VOICES+2 cycles.
REQ-022 Note-on with velocity 0 SHALL be treated as note-off.
REQ-023 Note-on selection priority:
  - active voice with the same note: retrigger it with the new velocity;
  - else the lowest-index inactive voice;
  - else steal the voice whose age = VOICES-1, and increment stealCount (saturating).
REQ-024 On note-on, the chosen voice gets: voiceActive=1, note and velocity loaded, and voiceTrigger pulsed high for exactly the one cycle following the COMMIT edge.
REQ-025 Age: per voice, clog2(VOICES) bits. On allocation of voice k, every voice with age < age[k] increments and age[k] becomes 0. Ages always form a permutation of 0..VOICES-1.
REQ-026 Note-off: every active voice holding evNote gets voiceActive=0 and note and velocity cleared to 0; ages are unchanged. A note-off with no match is a no-op.
REQ-027 evValid while evReady=0 SHALL be dropped (no buffering) and SHALL set overrun.
REQ-028 allOff is accepted in any state and has priority over evValid. At the next edge:
  - all voices are cleared;
  - any in-flight event is discarded;
  - the state returns to IDLE;
  - ages and stealCount are unchanged.
REQ-029 allOff and evValid in the same IDLE cycle: allOff wins; the event is dropped without setting overrun.

Reset
REQ-030 While rst_n=0, regardless of clock:
  - state = IDLE, evReady = 1;
  - voiceActive, voiceNote, voiceVelocity, voiceTrigger = 0;
  - stealCount = 0, overrun = 0;
  - age[i] = i.
REQ-031 Reset asserted mid-SCAN or mid-COMMIT SHALL abort the event with no table update.

Verification
REQ-032 VOICES=4; note-on 60/100 -> after 5 cycles voice0 active, note 60, velocity 100; voiceTrigger=0001 for one cycle.
REQ-033 Note-ons 60, 62, 64, 65, then 67 -> the fifth steals voice0 (age 3): voice0 note 67, stealCount=1, age permutation preserved.
REQ-034 Note-on 60, then note-on 60 velocity 0 -> voice0 inactive, note and velocity 0; then note-on 62 reuses voice0.
REQ-035 Note-on 60 twice with velocities 50 then 90 -> only voice0 used, velocity 90, two trigger pulses, stealCount=0.
REQ-036 evValid pulsed during SCAN -> event ignored and overrun=1; allOff during SCAN -> all voices cleared and IDLE the next cycle.
REQ-037 rst_n low mid-SCAN -> outputs reach reset values immediately, asynchronously; the first event after release goes to voice0.
